ld_frame_encoder: RTL and testbench

- Packs one rangefinder measurement into a 13-byte response frame and streams it byte-by-byte to the UART transmit path.
- Measurement fields: distance, speed, range-gate, status.
- Used for the loopback/emulation path, and as the stimulus source for the frame decoder in system test.
- Sits between the measurement source and a byte-wide UART transmitter using a valid/ready handshake.

---
 rtl/ld_pkg.sv | 30 +++
 rtl/ld_byte_mux.sv | 42 ++++
 rtl/ld_frame_encoder.sv | 167 ++++++++++++++++
 tb/tb_ld_frame_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_pkg.sv
// Shared constants and types for the rangefinder frame encoder and decoder.
package ld_pkg;

  localparam logic [7:0] HDR0_DEF   = 8'h55;
  localparam logic [7:0] HDR1_DEF   = 8'hAA;
  localparam logic [7:0] CMD_ID_DEF = 8'h88;

  localparam int unsigned FRAME_LEN = 13;

  localparam logic [3:0] IDX_HDR0    = 4'd0;
  localparam logic [3:0] IDX_HDR1    = 4'd1;
  localparam logic [3:0] IDX_CMD     = 4'd2;
  localparam logic [3:0] IDX_STATUS  = 4'd3;
  localparam logic [3:0] IDX_DIST_H  = 4'd4;
  localparam logic [3:0] IDX_DIST_L  = 4'd5;
  localparam logic [3:0] IDX_SPEED_H = 4'd6;
  localparam logic [3:0] IDX_SPEED_L = 4'd7;
  localparam logic [3:0] IDX_JL_H    = 4'd8;
  localparam logic [3:0] IDX_JL_L    = 4'd9;
  localparam logic [3:0] IDX_SEQ     = 4'd10;
  localparam logic [3:0] IDX_RSVD    = 4'd11;
  localparam logic [3:0] IDX_CSUM    = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/ld_byte_mux.sv
// Selects the outgoing frame byte by index from the captured measurement,
// sequence number and running checksum. Purely combinational.
module ld_byte_mux
  import ld_pkg::*;
#(
  parameter logic [7:0] HDR0   = HDR0_DEF,
  parameter logic [7:0] HDR1   = HDR1_DEF,
  parameter logic [7:0] CMD_ID = CMD_ID_DEF
) (
  input  logic [3:0]  i_idx,
  input  logic [7:0]  i_status,
  input  logic [15:0] i_dist,
  input  logic [15:0] i_speed,
  input  logic [15:0] i_jl,
  input  logic [7:0]  i_seq,
  input  logic [7:0]  i_csum,
  input  logic        i_csum_inv,
  output logic [7:0]  o_byte
);

  // Byte selection by frame position
  always_comb begin
    o_byte = '0;
    case (i_idx)
      IDX_HDR0:    o_byte = HDR0;
      IDX_HDR1:    o_byte = HDR1;
      IDX_CMD:     o_byte = CMD_ID;
      IDX_STATUS:  o_byte = i_status;
      IDX_DIST_H:  o_byte = i_dist[15:8];
      IDX_DIST_L:  o_byte = i_dist[7:0];
      IDX_SPEED_H: o_byte = i_speed[15:8];
      IDX_SPEED_L: o_byte = i_speed[7:0];
      IDX_JL_H:    o_byte = i_jl[15:8];
      IDX_JL_L:    o_byte = i_jl[7:0];
      IDX_SEQ:     o_byte = i_seq;
      IDX_RSVD:    o_byte = 8'h00;
      IDX_CSUM:    o_byte = i_csum ^ {8{i_csum_inv}};
      default:     o_byte = '0;
    endcase
  end

endmodule

// File: rtl/ld_frame_encoder.sv
// Packs one rangefinder measurement into a 13-byte response frame and
// streams it over a valid/ready byte interface.
// Optional macro LD_ERR_INJECT_EN adds i_err_inject, which corrupts the
// checksum byte of the frame accepted with it set.
module ld_frame_encoder
  import ld_pkg::*;
#(
  parameter logic [7:0]  HDR0      = HDR0_DEF,
  parameter logic [7:0]  HDR1      = HDR1_DEF,
  parameter logic [7:0]  CMD_ID    = CMD_ID_DEF,
  parameter int unsigned FRAME_GAP = 16
) (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic        i_meas_vld,
  output logic        o_meas_rdy,
  input  logic [15:0] i_dist,
  input  logic [15:0] i_speed,
  input  logic [15:0] i_jl,
  input  logic [7:0]  i_status,
`ifdef LD_ERR_INJECT_EN
  input  logic        i_err_inject,
`endif
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_vld,
  input  logic        i_tx_rdy,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [7:0]  o_drop_cnt
);

  localparam logic [15:0] GAP_LAST = (FRAME_GAP == 0) ? 16'd0 : 16'(FRAME_GAP - 1);

  ld_state_e   state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] dist_q, dist_d;
  logic [15:0] speed_q, speed_d;
  logic [15:0] jl_q, jl_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  drop_q, drop_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        err_in;
  logic [7:0]  mux_byte;

`ifdef LD_ERR_INJECT_EN
  assign err_in = i_err_inject;
`else
  assign err_in = 1'b0;
`endif

  ld_byte_mux #(
    .HDR0   (HDR0),
    .HDR1   (HDR1),
    .CMD_ID (CMD_ID)
  ) u_byte_mux (
    .i_idx      (idx_q),
    .i_status   (status_q),
    .i_dist     (dist_q),
    .i_speed    (speed_q),
    .i_jl       (jl_q),
    .i_seq      (seq_q),
    .i_csum     (acc_q),
    .i_csum_inv (err_q),
    .o_byte     (mux_byte)
  );

  // Frame sequencing, checksum accumulation and drop counting
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    seq_d    = seq_q;
    dist_d   = dist_q;
    speed_d  = speed_q;
    jl_d     = jl_q;
    status_d = status_q;
    gap_d    = gap_q;
    drop_d   = drop_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_meas_vld) begin
          dist_d   = i_dist;
          speed_d  = i_speed;
          jl_d     = i_jl;
          status_d = i_status;
          err_d    = err_in;
          idx_d    = '0;
          acc_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_tx_rdy) begin
          acc_d = acc_q + mux_byte;
          if (idx_q == IDX_CSUM) begin
            done_d  = 1'b1;
            seq_d   = seq_q + 8'd1;
            idx_d   = '0;
            gap_d   = '0;
            state_d = (FRAME_GAP == 0) ? ST_IDLE : ST_GAP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_meas_vld && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // State and datapath registers
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      seq_q    <= '0;
      dist_q   <= '0;
      speed_q  <= '0;
      jl_q     <= '0;
      status_q <= '0;
      gap_q    <= '0;
      drop_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      seq_q    <= seq_d;
      dist_q   <= dist_d;
      speed_q  <= speed_d;
      jl_q     <= jl_d;
      status_q <= status_d;
      gap_q    <= gap_d;
      drop_q   <= drop_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Output decode; the byte bus is forced to zero outside a frame
  always_comb begin
    o_meas_rdy   = (state_q == ST_IDLE);
    o_tx_vld     = (state_q == ST_SEND);
    o_busy       = (state_q != ST_IDLE);
    o_tx_byte    = (state_q == ST_SEND) ? mux_byte : '0;
    o_frame_done = done_q;
    o_drop_cnt   = drop_q;
  end

endmodule

// File: tb/tb_ld_frame_encoder.sv
// Self-checking bench for ld_frame_encoder: a cycle-based frame/timing model
// predicts every handshake output and byte from the measurements offered.
module tb_ld_frame_encoder;

  localparam int FRAME_GAP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_meas_vld;
  logic        o_meas_rdy;
  logic [15:0] i_dist, i_speed, i_jl;
  logic [7:0]  i_status;
  logic [7:0]  o_tx_byte;
  logic        o_tx_vld;
  logic        i_tx_rdy;
  logic        o_busy;
  logic        o_frame_done;
  logic [7:0]  o_drop_cnt;
`ifdef LD_ERR_INJECT_EN
  logic        i_err_inject;
`endif

  always #5 clk = ~clk;

  ld_frame_encoder #(
    .FRAME_GAP (FRAME_GAP)
  ) dut (
    .i_sys_clk    (clk),
    .i_reset      (rst),
    .i_meas_vld   (i_meas_vld),
    .o_meas_rdy   (o_meas_rdy),
    .i_dist       (i_dist),
    .i_speed      (i_speed),
    .i_jl         (i_jl),
    .i_status     (i_status),
`ifdef LD_ERR_INJECT_EN
    .i_err_inject (i_err_inject),
`endif
    .o_tx_byte    (o_tx_byte),
    .o_tx_vld     (o_tx_vld),
    .i_tx_rdy     (i_tx_rdy),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_drop_cnt   (o_drop_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_vec++;
    if (obs !== expd) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expd, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc = 0;
  bit         frame_open;
  int         byte_pos, accept_cyc, last_done_cyc, done_exp_cyc;
  int         drops_m, stall_m, vld_m, frames_done;
  logic [7:0] seq_m;
  logic [7:0] cur_frame [13];
  logic [7:0] obs_frame [13];
  logic [7:0] last_byte10, prev_byte10;
  bit         exp_rdy;

  task automatic build_frame(input logic [15:0] d, input logic [15:0] s, input logic [15:0] j,
                             input logic [7:0] st, input logic [7:0] sq, input bit e);
    int sum;
    cur_frame[0]  = 8'h55;
    cur_frame[1]  = 8'hAA;
    cur_frame[2]  = 8'h88;
    cur_frame[3]  = st;
    cur_frame[4]  = d / 256;
    cur_frame[5]  = d % 256;
    cur_frame[6]  = s / 256;
    cur_frame[7]  = s % 256;
    cur_frame[8]  = j / 256;
    cur_frame[9]  = j % 256;
    cur_frame[10] = sq;
    cur_frame[11] = 8'h00;
    sum = 0;
    for (int i = 0; i < 12; i++) sum += int'(cur_frame[i]);
    cur_frame[12] = 8'(sum % 256);
    if (e) cur_frame[12] = 8'hFF - cur_frame[12];
  endtask

  always @(negedge clk) begin
    bit e;
    cyc++;
    if (rst) begin
      frame_open    = 0;
      byte_pos      = 0;
      accept_cyc    = 0;
      last_done_cyc = -1000;
      done_exp_cyc  = -1;
      drops_m       = 0;
      frames_done   = 0;
      seq_m         = 8'h00;
    end else begin
      exp_rdy = !frame_open && (cyc - last_done_cyc > FRAME_GAP);
      chk("meas_rdy",   32'(o_meas_rdy),   32'(exp_rdy));
      chk("busy",       32'(o_busy),       32'(!exp_rdy));
      chk("tx_vld",     32'(o_tx_vld),     32'(frame_open && cyc > accept_cyc));
      chk("frame_done", 32'(o_frame_done), 32'(cyc == done_exp_cyc));
      chk("drop_cnt",   32'(o_drop_cnt),   32'(drops_m));
      if (o_tx_vld && frame_open) begin
        chk("tx_byte", 32'(o_tx_byte), 32'(cur_frame[byte_pos]));
        vld_m++;
        if (i_tx_rdy) begin
          obs_frame[byte_pos] = o_tx_byte;
          byte_pos++;
          if (byte_pos == 13) begin
            chk("send_cycles", 32'(vld_m), 32'(13 + stall_m));
            frame_open    = 0;
            last_done_cyc = cyc;
            done_exp_cyc  = cyc + 1;
            seq_m         = seq_m + 8'd1;
            frames_done++;
            prev_byte10   = last_byte10;
            last_byte10   = obs_frame[10];
          end
        end else begin
          stall_m++;
        end
      end
      if (i_meas_vld) begin
        if (exp_rdy) begin
          e = 0;
`ifdef LD_ERR_INJECT_EN
          e = i_err_inject;
`endif
          build_frame(i_dist, i_speed, i_jl, i_status, seq_m, e);
          frame_open = 1;
          accept_cyc = cyc;
          byte_pos   = 0;
          vld_m      = 0;
          stall_m    = 0;
        end else if (drops_m < 255) begin
          drops_m++;
        end
      end
    end
  end

  // ---------------- transmitter ready pattern ----------------
  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random
  initial begin
    i_tx_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       i_tx_rdy = 1'b1;
        1:       i_tx_rdy = ~i_tx_rdy;
        default: i_tx_rdy = 1'($urandom);
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [15:0] d, input logic [15:0] s, input logic [15:0] j,
                      input logic [7:0] st, input bit e);
    bit acc = 0;
    i_dist = d; i_speed = s; i_jl = j; i_status = st;
`ifdef LD_ERR_INJECT_EN
    i_err_inject = e;
`else
    if (e) $display("note: err inject requested without LD_ERR_INJECT_EN");
`endif
    i_meas_vld = 1'b1;
    for (int n = 0; n < 500 && !acc; n++) begin
      @(negedge clk);
      acc = o_meas_rdy;
      @(posedge clk);
      #1;
    end
    i_meas_vld = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int n = 0; n < 1000 && !idle; n++) begin
      @(negedge clk);
      #1;
      idle = !o_busy && !frame_open;
    end
    @(posedge clk);
    #1;
    if (!idle) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] basic [13];

  initial begin
    basic[0] = 8'h55; basic[1] = 8'hAA; basic[2]  = 8'h88; basic[3]  = 8'h00;
    basic[4] = 8'h12; basic[5] = 8'h34; basic[6]  = 8'h00; basic[7]  = 8'h56;
    basic[8] = 8'h00; basic[9] = 8'hC8; basic[10] = 8'h00; basic[11] = 8'h00;
    basic[12] = 8'hEB;
    rst = 1'b1;
    i_meas_vld = 1'b0;
    i_dist = '0; i_speed = '0; i_jl = '0; i_status = '0;
`ifdef LD_ERR_INJECT_EN
    i_err_inject = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_meas_rdy",   32'(o_meas_rdy),   32'd1);
    chk("rst_tx_vld",     32'(o_tx_vld),     32'd0);
    chk("rst_tx_byte",    32'(o_tx_byte),    32'd0);
    chk("rst_busy",       32'(o_busy),       32'd0);
    chk("rst_frame_done", 32'(o_frame_done), 32'd0);
    chk("rst_drop_cnt",   32'(o_drop_cnt),   32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic frame, transmitter always ready
    rdy_mode = 0;
    send(16'h1234, 16'h0056, 16'h00C8, 8'h00, 0);
    wait_idle();
    for (int i = 0; i < 13; i++) chk("basic_byte", 32'(obs_frame[i]), 32'(basic[i]));

    // backpressure: same fields, ready toggling
    rdy_mode = 1;
    send(16'h1234, 16'h0056, 16'h00C8, 8'h00, 0);
    wait_idle();
    for (int i = 0; i < 10; i++) chk("bp_byte", 32'(obs_frame[i]), 32'(basic[i]));
    chk("bp_seq",  32'(obs_frame[10]), 32'h01);
    chk("bp_csum", 32'(obs_frame[12]), 32'hEC);

    // drop and gap: measurement valid held for 40 cycles
    rdy_mode = 0;
    i_dist = 16'hBEEF; i_speed = 16'h0102; i_jl = 16'h0304; i_status = 8'h5A;
    i_meas_vld = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    i_meas_vld = 1'b0;
    wait_idle();

    // reset mid-frame after byte 5 has transferred
    send(16'hA5A5, 16'h5A5A, 16'h1111, 8'h77, 0);
    for (int n = 0; n < 100 && byte_pos < 6; n++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_reset_reached", 32'(byte_pos), 32'd6);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset_tx_vld",   32'(o_tx_vld),     32'd0);
    chk("mid_reset_busy",     32'(o_busy),       32'd0);
    chk("mid_reset_done",     32'(o_frame_done), 32'd0);
    chk("mid_reset_drop_cnt", 32'(o_drop_cnt),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'h1234, 16'h0056, 16'h00C8, 8'h00, 0);
    wait_idle();
    for (int i = 0; i < 13; i++) chk("post_reset_byte", 32'(obs_frame[i]), 32'(basic[i]));

`ifdef LD_ERR_INJECT_EN
    // corrupted checksum on an otherwise basic frame
    do_reset();
    send(16'h1234, 16'h0056, 16'h00C8, 8'h00, 1);
    wait_idle();
    for (int i = 0; i < 12; i++) chk("err_byte", 32'(obs_frame[i]), 32'(basic[i]));
    chk("err_csum", 32'(obs_frame[12]), 32'h14);
`endif

    // sequence wrap across 257 frames
    do_reset();
    for (int f = 0; f < 257; f++) send(16'h0000, 16'h0000, 16'h0000, 8'h00, 0);
    wait_idle();
    chk("wrap_frames",    32'(frames_done), 32'd257);
    chk("wrap_seq_ff",    32'(prev_byte10), 32'hFF);
    chk("wrap_seq_00",    32'(last_byte10), 32'h00);

    // drop counter saturation
    i_meas_vld = 1'b1;
    repeat (320) @(posedge clk);
    #1;
    i_meas_vld = 1'b0;
    @(negedge clk);
    chk("drop_sat", 32'(o_drop_cnt), 32'd255);
    wait_idle();

    // randomized measurements, gaps and backpressure
    do_reset();
    for (int f = 0; f < 60; f++) begin
      rdy_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
      send(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 1'($urandom));
    end
    rdy_mode = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
